// File: rtl/data_sram_responder_pkg.sv
// Shared types and helpers for the data-side SRAM responder: size encodings,
// response-queue entry payload and the byte-lane mask used for protocol checks.
package data_sram_responder_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned STRB_W = 4;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        SIZE_B   = 2'd0,
        SIZE_H   = 2'd1,
        SIZE_W   = 2'd2,
        SIZE_RSV = 2'd3
    } size_e;

    typedef struct packed {
        logic              is_wr;
        logic [DATA_W-1:0] rdata;
    } resp_entry_t;

    // Lanes a request of the given size may legally touch at this byte offset.
    function automatic logic [STRB_W-1:0] lane_mask(input logic [1:0] size,
                                                    input logic [1:0] off);
        case (size)
            SIZE_B:  lane_mask = STRB_W'(1) << off;
            SIZE_H:  lane_mask = off[1] ? 4'b1100 : 4'b0011;
            SIZE_W:  lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/data_sram_responder_if.sv
// Data-side SRAM-like request/response bus between the execute stage and its memory.
interface data_sram_responder_if;
    import data_sram_responder_pkg::*;

    logic              data_sram_req;
    logic              data_sram_wr;
    logic [1:0]        data_sram_size;
    logic [STRB_W-1:0] data_sram_wstrb;
    logic [ADDR_W-1:0] data_sram_addr;
    logic [DATA_W-1:0] data_sram_wdata;
    logic              data_sram_addr_ok;
    logic              data_sram_data_ok;
    logic [DATA_W-1:0] data_sram_rdata;

    modport master (
        output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
               data_sram_addr, data_sram_wdata,
        input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
    );

    modport slave (
        input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
               data_sram_addr, data_sram_wdata,
        output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
    );

endinterface

// File: rtl/data_sram_responder_resp_queue.sv
// In-order response queue: circular buffer with per-entry age counters; the head
// retires once it has aged RESP_LAT-1 cycles and retirement is not held.
module dsram_resp_queue
    import data_sram_responder_pkg::*;
#(
    parameter int unsigned QDEPTH   = 2,
    parameter int unsigned RESP_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  resp_entry_t       push_entry,
    input  logic              hold_next,
    output logic              not_full_c,
    output logic              data_ok,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(QDEPTH + 1);
    localparam int unsigned AGE_W = (RESP_LAT > 1) ? $clog2(RESP_LAT) : 1;

    resp_entry_t       ent_q [QDEPTH];
    resp_entry_t       ent_n [QDEPTH];
    logic [AGE_W-1:0]  age_q [QDEPTH];
    logic [AGE_W-1:0]  age_n [QDEPTH];
    logic [PTR_W-1:0]  head_q, head_n, tail_q, tail_n;
    logic [CNT_W-1:0]  count_q, count_n;
    logic              full, empty, pop, push_ok, ready_n;
    logic [DATA_W-1:0] rdata_n;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count_q == CNT_W'(QDEPTH));
    assign empty   = (count_q == '0);
    assign pop     = data_ok & ~empty;
    assign push_ok = push & ~full;

    // Next queue state; data_ok/rdata are registered from the state they will face.
    always_comb begin
        head_n  = pop ? ptr_inc(head_q) : head_q;
        tail_n  = push_ok ? ptr_inc(tail_q) : tail_q;
        count_n = count_q;
        if (push_ok && !pop)      count_n = count_q + CNT_W'(1);
        else if (!push_ok && pop) count_n = count_q - CNT_W'(1);
        for (int i = 0; i < int'(QDEPTH); i++) begin
            ent_n[i] = ent_q[i];
            age_n[i] = (age_q[i] == '1) ? age_q[i] : age_q[i] + AGE_W'(1);
            if (push_ok && tail_q == PTR_W'(i)) begin
                ent_n[i] = push_entry;
                age_n[i] = '0;
            end
        end
        ready_n    = (count_n != '0) && ((32'(age_n[head_n]) + 32'd1) >= RESP_LAT) && !hold_next;
        rdata_n    = (ready_n && !ent_n[head_n].is_wr) ? ent_n[head_n].rdata : '0;
        not_full_c = (count_n != CNT_W'(QDEPTH));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            data_ok <= 1'b0;
            rdata   <= '0;
            for (int i = 0; i < int'(QDEPTH); i++) begin
                ent_q[i] <= '0;
                age_q[i] <= '0;
            end
        end else begin
            head_q  <= head_n;
            tail_q  <= tail_n;
            count_q <= count_n;
            data_ok <= ready_n;
            rdata   <= rdata_n;
            for (int i = 0; i < int'(QDEPTH); i++) begin
                ent_q[i] <= ent_n[i];
                age_q[i] <= age_n[i];
            end
        end
    end

endmodule

// File: rtl/data_sram_responder.sv
// Data-memory responder for the SRAM-like bus: byte-masked writes and word reads on
// an internal RAM with in-order delayed responses. DSRAM_RAND_STALL_EN adds LFSR stalls.
module data_sram_responder
    import data_sram_responder_pkg::*;
#(
    parameter int unsigned AW_WORDS = 12,
    parameter int unsigned QDEPTH   = 2,
    parameter int unsigned RESP_LAT = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    data_sram_responder_if.slave  bus,
    output logic                  proto_err
);

    localparam int unsigned DEPTH = 1 << AW_WORDS;

    logic [DATA_W-1:0]   ram [DEPTH];
    logic [AW_WORDS-1:0] idx;
    logic                addr_ok_q, accept, violation;
    logic                not_full_c, stall_next, hold_next;
    logic                data_ok_q;
    logic [DATA_W-1:0]   rdata_q;
    resp_entry_t         push_entry;
    logic                unused_ok;

`ifdef DSRAM_RAND_STALL_EN
    localparam logic ADDR_OK_RST = ~LFSR_SEED[0];

    logic [15:0] lfsr_q, lfsr_n;

    assign lfsr_n = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    always_ff @(posedge clk) begin
        if (reset) lfsr_q <= LFSR_SEED;
        else       lfsr_q <= lfsr_n;
    end

    // Stall bits are registered alongside addr_ok/data_ok, so use next-cycle values.
    assign stall_next = lfsr_n[0];
    assign hold_next  = lfsr_n[1];
`else
    localparam logic ADDR_OK_RST = 1'b1;

    assign stall_next = 1'b0;
    assign hold_next  = 1'b0;
`endif

    assign idx       = bus.data_sram_addr[AW_WORDS+1:2];
    assign accept    = bus.data_sram_req & addr_ok_q & ~reset;
    assign unused_ok = ^{bus.data_sram_addr[ADDR_W-1:AW_WORDS+2]};

    assign bus.data_sram_addr_ok = addr_ok_q & ~reset;
    assign bus.data_sram_data_ok = data_ok_q;
    assign bus.data_sram_rdata   = rdata_q;

    always_comb begin
        push_entry.is_wr = bus.data_sram_wr;
        push_entry.rdata = bus.data_sram_wr ? '0 : ram[idx];
    end

    // Illegal size/alignment or strobes outside the lanes the size implies.
    always_comb begin
        violation = 1'b0;
        case (bus.data_sram_size)
            SIZE_H:   violation = bus.data_sram_addr[0];
            SIZE_W:   violation = |bus.data_sram_addr[1:0];
            SIZE_RSV: violation = 1'b1;
            default:  violation = 1'b0;
        endcase
        if (bus.data_sram_wr &&
            |(bus.data_sram_wstrb & ~lane_mask(bus.data_sram_size, bus.data_sram_addr[1:0])))
            violation = 1'b1;
    end

    // RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (accept && bus.data_sram_wr) begin
            for (int i = 0; i < int'(STRB_W); i++) begin
                if (bus.data_sram_wstrb[i]) ram[idx][8*i +: 8] <= bus.data_sram_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_ok_q <= ADDR_OK_RST;
            proto_err <= 1'b0;
        end else begin
            addr_ok_q <= not_full_c & ~stall_next;
            if (accept && violation) proto_err <= 1'b1;
        end
    end

    dsram_resp_queue #(
        .QDEPTH   (QDEPTH),
        .RESP_LAT (RESP_LAT)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .push       (accept),
        .push_entry (push_entry),
        .hold_next  (hold_next),
        .not_full_c (not_full_c),
        .data_ok    (data_ok_q),
        .rdata      (rdata_q)
    );

endmodule

// File: tb/tb_data_sram_responder.sv
// Scoreboard bench: instance a (RESP_LAT=1) for data/merge/random traffic, instance b
// (RESP_LAT=3) for full-queue back-pressure and reset-while-pending.
module tb_data_sram_responder;
    import data_sram_responder_pkg::*;

`ifdef DSRAM_RAND_STALL_EN
    localparam int N_RAND = 1000;
`else
    localparam int N_RAND = 300;
`endif

    typedef struct {
        logic [31:0] rdata;
        int          acc;
    } sb_t;

    logic clk = 1'b0;
    logic reset;
    logic a_perr, b_perr;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    sb_t         a_q[$], b_q[$];
    int          b_acc_cyc[$], b_resp_cyc[$];
    logic [31:0] a_mem [int];
    logic [31:0] b_mem [int];
    logic        a_perr_exp = 1'b0, b_perr_exp = 1'b0;
    logic [31:0] a_last = '0, b_last = '0;

    data_sram_responder_if a_bus ();
    data_sram_responder_if b_bus ();

    data_sram_responder #(.AW_WORDS(12), .QDEPTH(2), .RESP_LAT(1)) dut_a (
        .clk(clk), .reset(reset), .bus(a_bus), .proto_err(a_perr));

    data_sram_responder #(.AW_WORDS(12), .QDEPTH(2), .RESP_LAT(3)) dut_b (
        .clk(clk), .reset(reset), .bus(b_bus), .proto_err(b_perr));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] lanes(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            2'd0:    return 4'b0001 << off;
            2'd1:    return off[1] ? 4'b1100 : 4'b0011;
            2'd2:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic bad_req(input logic wr, input logic [1:0] sz,
                                     input logic [3:0] st, input logic [31:0] ad);
        return (sz == 2'd3) || (sz == 2'd1 && ad[0]) || (sz == 2'd2 && ad[1:0] != 2'b00) ||
               (wr && (st & ~lanes(sz, ad[1:0])) != 4'b0000);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] st);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (st[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    // Scoreboard for instance a: pop/compare on data_ok, push model result on accept.
    always @(negedge clk) begin
        sb_t e;
        int  k;
        if (reset) begin
            check("a_addr_ok_in_reset", {31'd0, a_bus.data_sram_addr_ok}, 32'd0);
            a_q.delete();
            a_perr_exp = 1'b0;
        end else begin
            check("a_proto_err", {31'd0, a_perr}, {31'd0, a_perr_exp});
`ifndef DSRAM_RAND_STALL_EN
            check("a_addr_ok", {31'd0, a_bus.data_sram_addr_ok}, 32'd1);
`endif
            if (a_bus.data_sram_data_ok) begin
                if (a_q.size() == 0) begin
                    check("a_spurious_data_ok", 32'd1, 32'd0);
                end else begin
                    e = a_q.pop_front();
                    check("a_rdata", a_bus.data_sram_rdata, e.rdata);
`ifdef DSRAM_RAND_STALL_EN
                    check("a_latency_min", {31'd0, (cyc - e.acc) >= 1}, 32'd1);
`else
                    check("a_latency", cyc - e.acc, 32'd1);
`endif
                    a_last = a_bus.data_sram_rdata;
                end
            end else begin
                check("a_rdata_idle", a_bus.data_sram_rdata, 32'd0);
            end
            if (a_bus.data_sram_req && a_bus.data_sram_addr_ok) begin
                k = int'(a_bus.data_sram_addr[13:2]);
                e.acc = cyc;
                if (a_bus.data_sram_wr) begin
                    e.rdata  = 32'd0;
                    a_mem[k] = merge(a_mem.exists(k) ? a_mem[k] : 32'hx,
                                     a_bus.data_sram_wdata, a_bus.data_sram_wstrb);
                end else begin
                    e.rdata = a_mem.exists(k) ? a_mem[k] : 32'hx;
                end
                a_q.push_back(e);
                if (bad_req(a_bus.data_sram_wr, a_bus.data_sram_size, a_bus.data_sram_wstrb,
                            a_bus.data_sram_addr)) a_perr_exp = 1'b1;
            end
        end
    end

    // Scoreboard for instance b, also logging accept and response cycles.
    always @(negedge clk) begin
        sb_t e;
        int  k;
        if (reset) begin
            check("b_addr_ok_in_reset", {31'd0, b_bus.data_sram_addr_ok}, 32'd0);
            b_q.delete();
            b_perr_exp = 1'b0;
        end else begin
            check("b_proto_err", {31'd0, b_perr}, {31'd0, b_perr_exp});
            if (b_bus.data_sram_data_ok) begin
                b_resp_cyc.push_back(cyc);
                if (b_q.size() == 0) begin
                    check("b_spurious_data_ok", 32'd1, 32'd0);
                end else begin
                    e = b_q.pop_front();
                    check("b_rdata", b_bus.data_sram_rdata, e.rdata);
                    check("b_latency_min", {31'd0, (cyc - e.acc) >= 3}, 32'd1);
                    b_last = b_bus.data_sram_rdata;
                end
            end else begin
                check("b_rdata_idle", b_bus.data_sram_rdata, 32'd0);
            end
            if (b_bus.data_sram_req && b_bus.data_sram_addr_ok) begin
                b_acc_cyc.push_back(cyc);
                k = int'(b_bus.data_sram_addr[13:2]);
                e.acc = cyc;
                if (b_bus.data_sram_wr) begin
                    e.rdata  = 32'd0;
                    b_mem[k] = merge(b_mem.exists(k) ? b_mem[k] : 32'hx,
                                     b_bus.data_sram_wdata, b_bus.data_sram_wstrb);
                end else begin
                    e.rdata = b_mem.exists(k) ? b_mem[k] : 32'hx;
                end
                b_q.push_back(e);
                if (bad_req(b_bus.data_sram_wr, b_bus.data_sram_size, b_bus.data_sram_wstrb,
                            b_bus.data_sram_addr)) b_perr_exp = 1'b1;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one request and hold it until accepted; returns just after the accept edge.
    task automatic issue(input bit to_b, input logic wr, input logic [1:0] sz,
                         input logic [3:0] st, input logic [31:0] ad, input logic [31:0] wd);
        bit ok;
        int budget;
        if (to_b) begin
            b_bus.data_sram_req = 1'b1; b_bus.data_sram_wr = wr; b_bus.data_sram_size = sz;
            b_bus.data_sram_wstrb = st; b_bus.data_sram_addr = ad; b_bus.data_sram_wdata = wd;
        end else begin
            a_bus.data_sram_req = 1'b1; a_bus.data_sram_wr = wr; a_bus.data_sram_size = sz;
            a_bus.data_sram_wstrb = st; a_bus.data_sram_addr = ad; a_bus.data_sram_wdata = wd;
        end
        ok = 1'b0;
        budget = 200;
        while (!ok && budget > 0) begin
            @(negedge clk);
            ok = to_b ? b_bus.data_sram_addr_ok : a_bus.data_sram_addr_ok;
            @(posedge clk);
            budget--;
        end
        if (!ok) check(to_b ? "b_accept_timeout" : "a_accept_timeout", 32'd0, 32'd1);
        #1;
        a_bus.data_sram_req = 1'b0;
        b_bus.data_sram_req = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  sz, off;
        logic [3:0]  st;
        logic [31:0] ad;
        logic        wr;

        reset = 1'b1;
        a_bus.data_sram_req = 1'b0; a_bus.data_sram_wr = 1'b0; a_bus.data_sram_size = 2'd0;
        a_bus.data_sram_wstrb = 4'h0; a_bus.data_sram_addr = '0; a_bus.data_sram_wdata = '0;
        b_bus.data_sram_req = 1'b0; b_bus.data_sram_wr = 1'b0; b_bus.data_sram_size = 2'd0;
        b_bus.data_sram_wstrb = 4'h0; b_bus.data_sram_addr = '0; b_bus.data_sram_wdata = '0;
        idle(3);
        reset = 1'b0;
        idle(2);

        // Word write then back-to-back read of the same word.
        issue(0, 1'b1, SIZE_W, 4'hF, 32'h100, 32'h11223344);
        issue(0, 1'b0, SIZE_W, 4'h0, 32'h100, 32'h0);
        idle(3);
        check("a_word_readback", a_last, 32'h11223344);

        // Byte store into lane 1, then read.
        issue(0, 1'b1, SIZE_B, 4'b0010, 32'h101, 32'hAAAAAAAA);
        issue(0, 1'b0, SIZE_W, 4'h0, 32'h100, 32'h0);
        idle(3);
        check("a_byte_merge", a_last, 32'h1122AA44);

        // Zero-strobe write is a no-op; half store to upper lanes; aliased upper address bits.
        issue(0, 1'b1, SIZE_W, 4'h0, 32'h100, 32'hFFFFFFFF);
        issue(0, 1'b1, SIZE_H, 4'b1100, 32'h102, 32'h55555555);
        issue(0, 1'b0, SIZE_W, 4'h0, 32'h8001_0100, 32'h0);
        idle(3);
        check("a_half_merge_alias", a_last, 32'h5555AA44);

        // Random legal traffic over a preloaded window.
        for (int i = 0; i < 16; i++) issue(0, 1'b1, SIZE_W, 4'hF, 32'h200 + 32'(4 * i), $urandom);
        for (int n = 0; n < N_RAND; n++) begin
            sz  = 2'($urandom_range(0, 2));
            off = (sz == 2'd0) ? 2'($urandom_range(0, 3)) : (sz == 2'd1) ? {1'($urandom_range(0, 1)), 1'b0} : 2'd0;
            ad  = (32'h200 + 32'(4 * $urandom_range(0, 15)) + 32'(off)) | ($urandom & 32'hFFFF_C000);
            st  = lanes(sz, off) & 4'($urandom);
            wr  = 1'($urandom_range(0, 1));
            issue(0, wr, sz, wr ? st : 4'h0, ad, $urandom);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(4);
        check("a_perr_clean_traffic", {31'd0, a_perr}, 32'd0);

        // Misaligned word read is answered and flags a sticky protocol error.
        issue(0, 1'b0, SIZE_W, 4'h0, 32'h102, 32'h0);
        idle(3);
        check("a_misaligned_rdata", a_last, 32'h5555AA44);
        check("a_perr_set", {31'd0, a_perr}, 32'd1);
        idle(5);
        check("a_perr_sticky", {31'd0, a_perr}, 32'd1);

        // Instance b: three back-to-back writes against a 2-deep queue with latency 3.
        b_acc_cyc.delete();
        b_resp_cyc.delete();
        issue(1, 1'b1, SIZE_W, 4'hF, 32'h0, 32'hA0A0A0A0);
        issue(1, 1'b1, SIZE_W, 4'hF, 32'h4, 32'hB1B1B1B1);
        issue(1, 1'b1, SIZE_W, 4'hF, 32'h8, 32'hC2C2C2C2);
        idle(8);
        check("b_resp_count", b_resp_cyc.size(), 32'd3);
`ifndef DSRAM_RAND_STALL_EN
        check("b_second_accept", b_acc_cyc[1] - b_acc_cyc[0], 32'd1);
        check("b_third_accept_after_retire", b_acc_cyc[2] - b_acc_cyc[0], 32'd4);
        check("b_first_resp", b_resp_cyc[0] - b_acc_cyc[0], 32'd3);
        check("b_second_resp", b_resp_cyc[1] - b_acc_cyc[0], 32'd4);
        check("b_third_resp", b_resp_cyc[2] - b_acc_cyc[0], 32'd7);
`endif
        issue(1, 1'b0, SIZE_W, 4'h0, 32'h0, 32'h0);
        issue(1, 1'b0, SIZE_W, 4'h0, 32'h4, 32'h0);
        issue(1, 1'b0, SIZE_W, 4'h0, 32'h8, 32'h0);
        idle(10);
        check("b_last_read", b_last, 32'hC2C2C2C2);

        // Reset while a read is pending: it must never be answered.
        issue(1, 1'b0, SIZE_W, 4'h0, 32'h4, 32'h0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
`ifndef DSRAM_RAND_STALL_EN
        check("b_addr_ok_after_reset", {31'd0, b_bus.data_sram_addr_ok}, 32'd1);
`endif
        check("a_perr_cleared", {31'd0, a_perr}, 32'd0);
        idle(8);
        b_last = '0;
        issue(1, 1'b0, SIZE_W, 4'h0, 32'h4, 32'h0);
        idle(10);
        check("b_ram_kept_over_reset", b_last, 32'hB1B1B1B1);

        idle(4);
        check("a_drained", a_q.size(), 32'd0);
        check("b_drained", b_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
